icache: RTL
===========

# icache

Read-only, direct-mapped instruction cache between the pipeline's fetch port (instr_read / instr_mem_address / instr_mem_rdata / instr_mem_resp) and a 256-bit line-granular physical memory port. It returns hits in the request cycle so the IF stage advances without stalling, and it runs a single-outstanding line fill on a miss. Two 32-bit event counters report hits and misses for performance bring-up.

## Interface
- S_INDEX, default 4: index bits; 2^S_INDEX sets, one 32-byte line each.
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- instr_read  input  1  fetch request, level-sensitive; the pipeline holds it high.
- instr_mem_address  input  32  byte address of the requested word.
- instr_mem_rdata  output  32  instruction word; valid only when instr_mem_resp=1.
- instr_mem_resp  output  1  request satisfied this cycle.
- pmem_read  output  1  line-fill request; held high until pmem_resp.
- pmem_address  output  32  line address, 32-byte aligned.
- pmem_rdata  input  256  fill data; byte 0 at bits [7:0].
- pmem_resp  input  1  fill data valid, one-cycle pulse.
- hit_count  output  32  number of hit responses.
- miss_count  output  32  number of fills started.

## Operation
- Address split: offset = addr[4:0], word select = addr[4:2], index = addr[4+S_INDEX:5], tag = addr[31:5+S_INDEX]; addr[1:0] ignored.
- Per set: valid bit, tag, 256-bit line, all in flops. Lookup is combinational.
- hit = instr_read & valid[index] & (tag_array[index] == tag) & (state == IDLE).
- instr_mem_rdata = line[index][32*word+31 : 32*word]. It is driven whenever hit is set and is don't-care otherwise.
- FSM states: IDLE and FETCH.
  - IDLE with instr_read & !hit: latch tag/index into fill_tag/fill_index, increment miss_count, go to FETCH.
  - IDLE with hit: instr_mem_resp=1, increment hit_count, stay in IDLE.
  - FETCH: pmem_read=1, pmem_address={fill_tag, fill_index, 5'b0}, instr_mem_resp=0.
  - FETCH with pmem_resp: write pmem_rdata into line[fill_index], set tag_array[fill_index]=fill_tag and valid[fill_index]=1, go to IDLE.
- The fill always completes to the latched address, even if instr_mem_address changes during FETCH (for example, on a pipeline flush). The new address is looked up in IDLE on the next cycle and may miss again.
- A conflicting fill overwrites the set. There is no write-back because the cache is read-only.
- pmem_resp arriving in IDLE is ignored.
- instr_read=0: instr_mem_resp=0, no fill starts, counters hold.
- Counters wrap modulo 2^32.

## Timing
- Reset (rst=1 at an edge): all valid bits=0, state=IDLE, hit_count=0, miss_count=0. Tag and data arrays are not cleared.
- Outputs during and after reset: pmem_read=0, instr_mem_resp=0.
- Reset mid-FETCH: state returns to IDLE the next edge and pmem_read drops. The line is not written and its valid bit stays 0. A later pmem_resp is ignored.
- Hit latency: 0 cycles. resp and rdata are combinational in the same cycle as the address.
- Miss latency, with memory responding N cycles after pmem_read rises (N≥1):
  - cycle 0: miss detected in IDLE;
  - cycles 1..N: FETCH;
  - cycle N+1: IDLE, hit, resp=1.
  - Total N+1 cycles of resp=0 before the response.
- pmem_read rises the cycle after miss detection. pmem_address is stable throughout FETCH.
- Simultaneous pmem_resp and rst: rst wins; no array write occurs.
- The pipeline samples rdata on the edge where resp=1; the cache makes no assumption about when the next address is presented.

## Test plan
- Cold miss: after reset, read 0x0000_0040 with memory N=3 and line word1 = 0xDEAD_BEEF.
  - pmem_read=1 with pmem_address=0x0000_0040 for 3 cycles.
  - Then resp=1 with rdata=0xDEAD_BEEF for a read of 0x44 on the cycle after the fill.
  - miss_count=1.
- Hit streak: after the fill, read 0x40, 0x44 … 0x5C on consecutive cycles.
  - resp=1 every cycle, 8 correct words, no pmem_read.
  - hit_count increments by 8.
- Conflict eviction (S_INDEX=4): fill 0x0000_0040, then read 0x0000_0240, which has the same index and a different tag.
  - Miss with pmem_address=0x0000_0240.
  - A subsequent read of 0x40 misses again; miss_count=3.
- Address change mid-fill: miss on 0x100, switch the address to 0x200 while in FETCH.
  - Fill completes for 0x100 and its set becomes valid.
  - 0x200 then misses with pmem_address=0x200.
- Reset mid-fill: assert rst for one cycle during FETCH, then pulse pmem_resp.
  - pmem_read=0 after reset and no array update.
  - Re-reading the address misses; counters read 0 after reset.
- Idle: instr_read=0 for 10 cycles with a valid resident line.
  - resp=0, pmem_read=0, counters unchanged.

Source files
------------

// File: rtl/icache.sv
// Read-only direct-mapped instruction cache: zero-latency hits and a single
// outstanding 256-bit line fill on a miss, plus hit/miss event counters.
module icache #(
    parameter int S_INDEX = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         instr_read,
    input  logic [31:0]  instr_mem_address,
    output logic [31:0]  instr_mem_rdata,
    output logic         instr_mem_resp,
    output logic         pmem_read,
    output logic [31:0]  pmem_address,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
);
    localparam int SETS  = 2 ** S_INDEX;
    localparam int TAG_W = 27 - S_INDEX;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t             state_r;
    logic [SETS-1:0]    valid_r;
    logic [TAG_W-1:0]   tag_r  [SETS];
    logic [255:0]       line_r [SETS];
    logic [TAG_W-1:0]   fill_tag_r;
    logic [S_INDEX-1:0] fill_index_r;
    logic               pmem_read_r;
    logic [31:0]        hit_count_r;
    logic [31:0]        miss_count_r;

    logic [S_INDEX-1:0] index_s;
    logic [TAG_W-1:0]   tag_s;
    logic [2:0]         word_s;
    logic [1:0]         byte_sel_unused_s;
    logic               hit_s;
    logic [31:0]        rdata_s;
    logic               fill_write_s;

    assign index_s           = instr_mem_address[4+S_INDEX:5];
    assign tag_s             = instr_mem_address[31:5+S_INDEX];
    assign word_s            = instr_mem_address[4:2];
    assign byte_sel_unused_s = instr_mem_address[1:0];

    // Combinational lookup: hits answer in the same cycle the address arrives
    always_comb begin
        hit_s   = 1'b0;
        rdata_s = 32'd0;
        if (instr_read && (state_r == IDLE) && valid_r[index_s] &&
            (tag_r[index_s] == tag_s)) begin
            hit_s   = 1'b1;
            rdata_s = line_r[index_s][{word_s, 5'b00000} +: 32];
        end else begin
            hit_s   = 1'b0;
            rdata_s = 32'd0;
        end
    end

    // Reset outranks a coincident fill response, so the arrays stay untouched
    assign fill_write_s = !rst && (state_r == FETCH) && pmem_resp;

    // Control FSM, valid bits and event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            valid_r      <= {SETS{1'b0}};
            pmem_read_r  <= 1'b0;
            hit_count_r  <= 32'd0;
            miss_count_r <= 32'd0;
            fill_tag_r   <= {TAG_W{1'b0}};
            fill_index_r <= {S_INDEX{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (instr_read && !hit_s) begin
                        fill_tag_r   <= tag_s;
                        fill_index_r <= index_s;
                        pmem_read_r  <= 1'b1;
                        miss_count_r <= miss_count_r + 32'd1;
                        state_r      <= FETCH;
                    end else if (hit_s) begin
                        hit_count_r <= hit_count_r + 32'd1;
                    end
                end
                FETCH: begin
                    // The fill always lands at the latched set, whatever the
                    // fetch address is doing meanwhile
                    if (pmem_resp) begin
                        valid_r[fill_index_r] <= 1'b1;
                        pmem_read_r           <= 1'b0;
                        state_r               <= IDLE;
                    end
                end
                default: begin
                    pmem_read_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    // Tag and data storage; left uncleared by reset since valid bits gate use
    always_ff @(posedge clk) begin
        if (fill_write_s) begin
            line_r[fill_index_r] <= pmem_rdata;
            tag_r[fill_index_r]  <= fill_tag_r;
        end
    end

    assign instr_mem_resp  = hit_s;
    assign instr_mem_rdata = rdata_s;
    assign pmem_read       = pmem_read_r;
    assign pmem_address    = {fill_tag_r, fill_index_r, 5'b00000};
    assign hit_count       = hit_count_r;
    assign miss_count      = miss_count_r;

endmodule
